rtc_port_sequencer: RTL

RTC_PORT_SEQUENCER -- requirements
Module: rtc_port_sequencer

---
 rtl/rtc_pkg.sv | 35 +++
 rtl/rtc_days_in_month.sv | 23 ++
 rtl/rtc_port_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared field indices, FSM states and field range limits for the RTC port sequencer.
package rtc_pkg;
    localparam int unsigned NUM_FIELDS = 6;

    localparam logic [3:0] OP_PORT_WRITE = 4'b0011;
    localparam logic [3:0] OP_NONE       = 4'b0000;

    localparam int unsigned SEC_MIN   = 0;
    localparam int unsigned SEC_MAX   = 59;
    localparam int unsigned MIN_MIN   = 0;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned HOUR_MIN  = 0;
    localparam int unsigned HOUR_MAX  = 23;
    localparam int unsigned DAY_MIN   = 1;
    localparam int unsigned MONTH_MIN = 1;
    localparam int unsigned MONTH_MAX = 12;
    localparam int unsigned YEAR_MIN  = 0;
    localparam int unsigned YEAR_MAX  = 9999;
    localparam int unsigned YEAR_RST  = 2000;

    typedef enum logic [2:0] {
        FLD_SEC   = 3'd0,
        FLD_MIN   = 3'd1,
        FLD_HOUR  = 3'd2,
        FLD_DAY   = 3'd3,
        FLD_MONTH = 3'd4,
        FLD_YEAR  = 3'd5
    } field_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } state_e;
endpackage

// File: rtl/rtc_days_in_month.sv
// Combinational days-in-month lookup with the Gregorian leap-year rule.
module rtc_days_in_month #(
    parameter int unsigned data_size = 16
) (
    input  logic [data_size-1:0] i_month,
    input  logic [data_size-1:0] i_year,
    output logic [data_size-1:0] o_dim
);
    logic w_leap;

    always_comb begin
        w_leap = ((i_year % data_size'(4)) == '0) &&
                 (((i_year % data_size'(100)) != '0) || ((i_year % data_size'(400)) == '0));
        case (i_month)
            data_size'(2):  o_dim = w_leap ? data_size'(29) : data_size'(28);
            data_size'(4),
            data_size'(6),
            data_size'(9),
            data_size'(11): o_dim = data_size'(30);
            default:        o_dim = data_size'(31);
        endcase
    end
endmodule

// File: rtl/rtc_port_sequencer.sv
// Real-time clock with software field writes; changed fields are pushed out
// over the MiscManager port bus one write per granted cycle, lowest index first.
module rtc_port_sequencer
    import rtc_pkg::*;
#(
    parameter int unsigned data_size     = 16,
    parameter int unsigned TICKS_PER_SEC = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 set_valid,
    input  logic [2:0]           set_field,
    input  logic [data_size-1:0] set_value,
    output logic                 set_err,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic                 cs,
    output logic [3:0]           op,
    output logic [data_size-1:0] port,
    output logic [data_size-1:0] data,
    output logic                 busy
);
    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TC = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0]         r_presc;
    logic [data_size-1:0]  r_field [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] r_dirty;
    logic                  r_set_err;
    state_e                r_state;

    logic                  w_at_tc, w_tick, w_set_ok;
    logic                  w_c_min, w_c_hour, w_c_day, w_c_month, w_c_year;
    logic [data_size-1:0]  w_field_nxt [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] w_dirty_set, w_clr, w_dirty_nxt;
    logic [data_size-1:0]  w_dim_cur, w_dim_new, w_month_new, w_year_new;
    logic [2:0]            w_wr_idx;
    logic                  w_wr;
    state_e                w_state_nxt;

    assign w_month_new = (set_field == FLD_MONTH) ? set_value : r_field[FLD_MONTH];
    assign w_year_new  = (set_field == FLD_YEAR)  ? set_value : r_field[FLD_YEAR];

    rtc_days_in_month #(.data_size(data_size)) u_dim_cur (
        .i_month (r_field[FLD_MONTH]),
        .i_year  (r_field[FLD_YEAR]),
        .o_dim   (w_dim_cur)
    );

    // Month length after a pending month/year set, used to clamp the day.
    rtc_days_in_month #(.data_size(data_size)) u_dim_new (
        .i_month (w_month_new),
        .i_year  (w_year_new),
        .o_dim   (w_dim_new)
    );

    // A set in the terminal-count cycle holds the prescaler, deferring the tick.
    assign w_at_tc = (r_presc == TC);
    assign w_tick  = run && w_at_tc && !set_valid;

    assign w_c_min   = (r_field[FLD_SEC] == data_size'(SEC_MAX));
    assign w_c_hour  = w_c_min && (r_field[FLD_MIN] == data_size'(MIN_MAX));
    assign w_c_day   = w_c_hour && (r_field[FLD_HOUR] == data_size'(HOUR_MAX));
    assign w_c_month = w_c_day && (r_field[FLD_DAY] >= w_dim_cur);
    assign w_c_year  = w_c_month && (r_field[FLD_MONTH] == data_size'(MONTH_MAX));

    // Field update: validated software set, else carry chain on a tick.
    always_comb begin
        for (int i = 0; i < NUM_FIELDS; i++) w_field_nxt[i] = r_field[i];
        w_dirty_set = '0;
        w_set_ok    = 1'b0;
        if (set_valid) begin
            case (set_field)
                FLD_SEC:   w_set_ok = (set_value <= data_size'(SEC_MAX));
                FLD_MIN:   w_set_ok = (set_value <= data_size'(MIN_MAX));
                FLD_HOUR:  w_set_ok = (set_value <= data_size'(HOUR_MAX));
                FLD_DAY:   w_set_ok = (set_value >= data_size'(DAY_MIN)) && (set_value <= w_dim_cur);
                FLD_MONTH: w_set_ok = (set_value >= data_size'(MONTH_MIN)) && (set_value <= data_size'(MONTH_MAX));
                FLD_YEAR:  w_set_ok = (set_value <= data_size'(YEAR_MAX));
                default:   w_set_ok = 1'b0;
            endcase
            if (w_set_ok) begin
                w_field_nxt[set_field] = set_value;
                w_dirty_set[set_field] = 1'b1;
                if (((set_field == FLD_MONTH) || (set_field == FLD_YEAR)) &&
                    (r_field[FLD_DAY] > w_dim_new)) begin
                    w_field_nxt[FLD_DAY] = w_dim_new;
                    w_dirty_set[FLD_DAY] = 1'b1;
                end
            end
        end else if (w_tick) begin
            w_field_nxt[FLD_SEC] = w_c_min ? data_size'(SEC_MIN) : r_field[FLD_SEC] + data_size'(1);
            w_dirty_set[FLD_SEC] = 1'b1;
            if (w_c_min) begin
                w_field_nxt[FLD_MIN] = w_c_hour ? data_size'(MIN_MIN) : r_field[FLD_MIN] + data_size'(1);
                w_dirty_set[FLD_MIN] = 1'b1;
            end
            if (w_c_hour) begin
                w_field_nxt[FLD_HOUR] = w_c_day ? data_size'(HOUR_MIN) : r_field[FLD_HOUR] + data_size'(1);
                w_dirty_set[FLD_HOUR] = 1'b1;
            end
            if (w_c_day) begin
                w_field_nxt[FLD_DAY] = w_c_month ? data_size'(DAY_MIN) : r_field[FLD_DAY] + data_size'(1);
                w_dirty_set[FLD_DAY] = 1'b1;
            end
            if (w_c_month) begin
                w_field_nxt[FLD_MONTH] = w_c_year ? data_size'(MONTH_MIN) : r_field[FLD_MONTH] + data_size'(1);
                w_dirty_set[FLD_MONTH] = 1'b1;
            end
            if (w_c_year) begin
                w_field_nxt[FLD_YEAR] = (r_field[FLD_YEAR] >= data_size'(YEAR_MAX)) ?
                                        data_size'(YEAR_MIN) : r_field[FLD_YEAR] + data_size'(1);
                w_dirty_set[FLD_YEAR] = 1'b1;
            end
        end
    end

    always_comb begin
        w_wr_idx = 3'd0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if (r_dirty[i]) w_wr_idx = 3'(i);
        end
    end

    // Clearing the written bit and re-dirtying in the same cycle: re-dirty wins.
    assign w_wr        = (r_state == ST_WRITE) && bus_gnt && !rst && (r_dirty != '0);
    assign w_clr       = w_wr ? (NUM_FIELDS'(1) << w_wr_idx) : '0;
    assign w_dirty_nxt = (r_dirty & ~w_clr) | w_dirty_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc            <= '0;
            r_field[FLD_SEC]   <= data_size'(SEC_MIN);
            r_field[FLD_MIN]   <= data_size'(MIN_MIN);
            r_field[FLD_HOUR]  <= data_size'(HOUR_MIN);
            r_field[FLD_DAY]   <= data_size'(DAY_MIN);
            r_field[FLD_MONTH] <= data_size'(MONTH_MIN);
            r_field[FLD_YEAR]  <= data_size'(YEAR_RST);
            r_dirty            <= '1;
            r_set_err          <= 1'b0;
        end else begin
            if (run && !(w_at_tc && set_valid)) r_presc <= w_at_tc ? '0 : r_presc + PW'(1);
            for (int i = 0; i < NUM_FIELDS; i++) r_field[i] <= w_field_nxt[i];
            r_dirty   <= w_dirty_nxt;
            r_set_err <= set_valid && !w_set_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (r_dirty != '0) w_state_nxt = ST_REQ;
            ST_REQ:   if (bus_gnt) w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (!bus_gnt)               w_state_nxt = ST_REQ;
                else if (w_dirty_nxt == '0) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs follow grant within the cycle; reset suppresses them at once.
    always_comb begin
        cs      = 1'b0;
        op      = OP_NONE;
        port    = '0;
        data    = '0;
        bus_req = !rst && (r_state != ST_IDLE);
        busy    = !rst && (r_state != ST_IDLE);
        if (w_wr) begin
            cs   = 1'b1;
            op   = OP_PORT_WRITE;
            port = data_size'(w_wr_idx);
            data = r_field[w_wr_idx];
        end
    end

    assign set_err = r_set_err;
endmodule
